// File: rtl/led_matrix_pwm_driver_if.sv
// Frame handshake between the render logic (master) and the matrix driver (slave).
interface led_matrix_pwm_driver_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int BITS = 2
);
  localparam int PIX = ROWS * COLS * BITS;

  logic [PIX-1:0] red_pixels;
  logic [PIX-1:0] green_pixels;
  logic           frame_valid;
  logic           frame_ready;

  modport master (output red_pixels, output green_pixels, output frame_valid, input frame_ready);
  modport slave  (input red_pixels, input green_pixels, input frame_valid, output frame_ready);
endinterface

// File: rtl/led_matrix_pwm_driver.sv
// Row-scanned dual-colour LED matrix driver with per-pixel PWM, inter-row blanking and a
// double-buffered (pending/display) frame store that swaps only at frame boundaries.

// One column: light each colour while its intensity exceeds the current PWM phase.
module led_matrix_pwm_lane #(
  parameter int BITS = 2
) (
  input  logic [BITS-1:0] red,
  input  logic [BITS-1:0] green,
  input  logic [BITS-1:0] phase,
  output logic            red_on,
  output logic            green_on
);
  assign red_on   = red > phase;
  assign green_on = green > phase;
endmodule

module led_matrix_pwm_driver #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int BITS         = 2,
  parameter int SLOT_CYCLES  = 4,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  led_matrix_pwm_driver_if.slave frame,
  output logic [COLS-1:0]        red_driver,
  output logic [COLS-1:0]        green_driver,
  output logic [ROWS-1:0]        row_sink,
  output logic                   frame_start
);
  localparam int PIX     = ROWS * COLS * BITS;
  localparam int RB      = COLS * BITS;
  localparam int PHASES  = (1 << BITS) - 1;
  localparam int CNT_MAX = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(ROWS);

  typedef enum logic {BLANK, ACTIVE} state_t;

  state_t          state;
  logic            boot;   // first edge after reset acts as a frame boundary
  logic [CW-1:0]   cnt;
  logic [RW-1:0]   row;
  logic [BITS-1:0] phase;
  logic [PIX-1:0]  disp_r, disp_g, pend_r, pend_g;

  logic            slot_end, blank_end, row_end, boundary;
  logic [BITS-1:0] cmp_phase;
  logic [RB-1:0]   row_r, row_g;
  logic [COLS-1:0] lit_r, lit_g;

  assign slot_end  = cnt == CW'(SLOT_CYCLES - 1);
  assign blank_end = cnt == CW'(BLANK_CYCLES - 1);
  assign row_end   = (state == ACTIVE) && slot_end && (phase == BITS'(PHASES - 1));
  assign boundary  = boot || (row_end && (row == RW'(ROWS - 1)));

  // Drivers are loaded for the phase about to start: phase 0 when leaving BLANK, else phase+1.
  assign cmp_phase = (state == ACTIVE) ? phase + 1'b1 : '0;
  assign row_r     = disp_r[int'(row) * RB +: RB];
  assign row_g     = disp_g[int'(row) * RB +: RB];

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    led_matrix_pwm_lane #(.BITS(BITS)) u_lane (
      .red      (row_r[c*BITS +: BITS]),
      .green    (row_g[c*BITS +: BITS]),
      .phase    (cmp_phase),
      .red_on   (lit_r[c]),
      .green_on (lit_g[c])
    );
  end

  // Scan FSM: blank/active timing, row walk and registered pin outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= BLANK;
      boot         <= 1'b1;
      cnt          <= '0;
      row          <= '0;
      phase        <= '0;
      red_driver   <= '0;
      green_driver <= '0;
      row_sink     <= '1;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= boundary;
      boot        <= 1'b0;
      if (boot) begin
        state <= BLANK;
        cnt   <= '0;
        row   <= '0;
      end else begin
        case (state)
          BLANK: begin
            if (blank_end) begin
              state        <= ACTIVE;
              cnt          <= '0;
              phase        <= '0;
              red_driver   <= lit_r;
              green_driver <= lit_g;
              row_sink     <= ~(ROWS'(1) << row);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ACTIVE: begin
            if (slot_end) begin
              cnt <= '0;
              if (phase == BITS'(PHASES - 1)) begin
                // columns off before the row select moves
                state        <= BLANK;
                red_driver   <= '0;
                green_driver <= '0;
                row_sink     <= '1;
                row          <= (row == RW'(ROWS - 1)) ? '0 : row + 1'b1;
              end else begin
                phase        <= phase + 1'b1;
                red_driver   <= lit_r;
                green_driver <= lit_g;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= BLANK;
        endcase
      end
    end
  end

  // Frame buffers: accept into pending when empty, move to display only at a boundary.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend_r            <= '0;
      pend_g            <= '0;
      disp_r            <= '0;
      disp_g            <= '0;
      frame.frame_ready <= 1'b1;
    end else if (frame.frame_valid && frame.frame_ready) begin
      pend_r            <= frame.red_pixels;
      pend_g            <= frame.green_pixels;
      frame.frame_ready <= 1'b0;
    end else if (boundary && !frame.frame_ready) begin
      disp_r            <= pend_r;
      disp_g            <= pend_g;
      frame.frame_ready <= 1'b1;
    end
  end
endmodule

// File: tb/tb_led_matrix_pwm_driver.sv
// Bench for led_matrix_pwm_driver: cycle-position model checked every cycle, plus literal pins.
module tb_led_matrix_pwm_driver;
  localparam int ROWS = 8, COLS = 8, BITS = 2, SLOT = 4, BLANK = 2;
  localparam int ROWP   = BLANK + ((1 << BITS) - 1) * SLOT;  // 14
  localparam int FRAMEP = ROWS * ROWP;                        // 112
  localparam int PIX    = ROWS * COLS * BITS;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [COLS-1:0] red_driver, green_driver;
  logic [ROWS-1:0] row_sink;
  logic            frame_start;

  led_matrix_pwm_driver_if #(.ROWS(ROWS), .COLS(COLS), .BITS(BITS)) bus ();

  led_matrix_pwm_driver #(
    .ROWS(ROWS), .COLS(COLS), .BITS(BITS), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .frame        (bus),
    .red_driver   (red_driver),
    .green_driver (green_driver),
    .row_sink     (row_sink),
    .frame_start  (frame_start)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: position in frame from edges since reset release ----------------
  int n;
  logic m_ready;
  logic [PIX-1:0] m_pr, m_pg, m_dr, m_dg;
  int pos, r, w, ph;
  logic [COLS-1:0] er, eg;
  logic [ROWS-1:0] es;
  logic ef;

  always @(negedge clock) begin
    if (!reset_n) begin
      n = 0; m_ready = 1'b1; m_pr = '0; m_pg = '0; m_dr = '0; m_dg = '0;
      chk("m_rst_sink", row_sink, 8'hFF);
      chk("m_rst_red", red_driver, 8'h00);
      chk("m_rst_green", green_driver, 8'h00);
      chk("m_rst_ready", bus.frame_ready, 1);
      chk("m_rst_fs", frame_start, 0);
    end else begin
      er = '0; eg = '0; es = '1; ef = 1'b0;
      if (n >= 1) begin
        pos = (n - 1) % FRAMEP;
        r   = pos / ROWP;
        w   = pos % ROWP;
        ef  = (pos == 0);
        if (w >= BLANK) begin
          ph    = (w - BLANK) / SLOT;
          es[r] = 1'b0;
          for (int c = 0; c < COLS; c++) begin
            er[c] = int'(m_dr[(r*COLS + c)*BITS +: BITS]) > ph;
            eg[c] = int'(m_dg[(r*COLS + c)*BITS +: BITS]) > ph;
          end
        end
      end
      chk("m_sink", row_sink, es);
      chk("m_red", red_driver, er);
      chk("m_green", green_driver, eg);
      chk("m_fs", frame_start, ef);
      chk("m_ready", bus.frame_ready, m_ready);
      // effect of the coming edge (edge n+1 is a boundary when n is a multiple of FRAMEP)
      if (bus.frame_valid && m_ready) begin
        m_pr = bus.red_pixels; m_pg = bus.green_pixels; m_ready = 1'b0;
      end else if ((n % FRAMEP) == 0 && !m_ready) begin
        m_dr = m_pr; m_dg = m_pg; m_ready = 1'b1;
      end
      n++;
    end
  end

  // ---------------- directed stimulus ----------------
  int e;
  logic [PIX-1:0] a_r, a_g, b_r, b_g, c_r, c_g;

  task automatic tick();
    @(posedge clock); #1; e++;
  endtask

  task automatic run_to(input int t);
    while (e < t) tick();
    #3;
  endtask

  initial begin
    a_r = '1; a_g = '0;
    b_r = '0; b_g = '0;
    b_r[(2*COLS + 0)*BITS +: BITS] = 2'd1;
    b_r[(2*COLS + 1)*BITS +: BITS] = 2'd2;
    b_r[(2*COLS + 2)*BITS +: BITS] = 2'd3;
    for (int c = 0; c < COLS; c++) b_g[(3*COLS + c)*BITS +: BITS] = 2'd3;
    c_r = '0;
    for (int i = 0; i < ROWS*COLS; i++) c_g[i*BITS +: BITS] = 2'd1;

    bus.frame_valid = 1'b0; bus.red_pixels = '0; bus.green_pixels = '0;
    e = 0;
    repeat (3) @(posedge clock);
    #4;
    chk("rst_sink", row_sink, 8'hFF);
    chk("rst_ready", bus.frame_ready, 1);
    @(posedge clock); #1;
    reset_n = 1'b1; e = 0;

    // empty display: only the row walk is visible
    run_to(3);   chk("row0_sink", row_sink, 8'hFE); chk("row0_red_off", red_driver, 8'h00);
    run_to(2);
    run_to(17);  chk("row1_sink", row_sink, 8'hFD);
    run_to(101); chk("row7_sink", row_sink, 8'h7F);
    run_to(113); chk("fs_frame1", frame_start, 1);

    // frame A offered, then B back-to-back
    run_to(230);
    bus.red_pixels = a_r; bus.green_pixels = a_g; bus.frame_valid = 1'b1;
    tick();
    bus.red_pixels = b_r; bus.green_pixels = b_g;
    run_to(300); chk("ready_stall", bus.frame_ready, 0);
    run_to(337); chk("ready_swapA", bus.frame_ready, 1); chk("fs_swapA", frame_start, 1);
    tick();      #3; chk("ready_accB", bus.frame_ready, 0); chk("fs_one_cycle", frame_start, 0);
    bus.frame_valid = 1'b0;
    run_to(340); chk("A_row0_red", red_driver, 8'hFF); chk("A_row0_green", green_driver, 8'h00);
    run_to(386); chk("A_row3_red", red_driver, 8'hFF); chk("A_row3_sink", row_sink, 8'hF7);
    run_to(449); chk("fs_swapB", frame_start, 1);

    // frame C sits in pending while B is shown
    run_to(460);
    bus.red_pixels = c_r; bus.green_pixels = c_g; bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    run_to(479); chk("B_row2_p0", red_driver, 8'h07); chk("B_row2_sink", row_sink, 8'hFB);
    run_to(483); chk("B_row2_p1", red_driver, 8'h06);
    run_to(487); chk("B_row2_p2", red_driver, 8'h04);
    run_to(494); chk("B_row3_green", green_driver, 8'hFF); chk("B_row3_red", red_driver, 8'h00);

    // reset in the middle of row 5
    run_to(524); chk("row5_sink", row_sink, 8'hDF); chk("pend_full", bus.frame_ready, 0);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_sink", row_sink, 8'hFF);
    chk("mid_rst_green", green_driver, 8'h00);
    chk("mid_rst_ready", bus.frame_ready, 1);
    repeat (2) @(posedge clock);
    #1; reset_n = 1'b1; e = 0;
    run_to(3);          chk("restart_sink", row_sink, 8'hFE); chk("restart_cleared", green_driver, 8'h00);
    run_to(FRAMEP + 1); chk("restart_fs", frame_start, 1); chk("restart_ready", bus.frame_ready, 1);
    run_to(FRAMEP + 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
